// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests for loads and stores,
// extracts/extends load data, resolves the writeback destination and
// registers the writeback bundle. Misaligned accesses complete at once
// with an error pulse and no memory request.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        dm_we,
   input  logic        r_we,
   input  logic [1:0]  r_dst,
   input  logic [1:0]  rw_d,
   input  logic [1:0]  mem_read_size,
   input  logic        mem_sign_extend,
   input  logic [31:0] pc,
   input  logic [31:0] insn,
   input  logic [31:0] alu_out,
   input  logic [31:0] rt_val,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_r_we,
   output logic [4:0]  wb_dst,
   output logic [31:0] wb_data,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_insn,
   output logic        misalign_err
);

   // Handshake: dmem_req stays high (with stable we/addr/be/wdata) from the
   // edge entering WAIT until the edge on which dmem_ack=1 is sampled.
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_WAIT = 1'b1;

   logic        state_q, state_d;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q, dmem_wdata_q;
   logic [3:0]  dmem_be_q;
   logic        wb_valid_q, wb_r_we_q, misalign_err_q;
   logic [4:0]  wb_dst_q;
   logic [31:0] wb_data_q, wb_pc_q, wb_insn_q;

   logic        mem_op, misaligned, start_op, complete;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, load_val, data_c;
   logic [4:0]  dst_c;
   logic [15:0] half_c;
   logic [7:0]  byte_c;

   // Decode the access, build lane enables/store data and the writeback value.
   always_comb begin
      mem_op     = in_valid & (dm_we | (rw_d == 2'd1));
      misaligned = mem_op & (((mem_read_size == 2'd1) & alu_out[0]) |
                             ((mem_read_size == 2'd0) & (alu_out[1:0] != 2'b00)));
      start_op   = mem_op & ~misaligned;
      be_c       = 4'b1111;
      wdata_c    = rt_val;
      if (dm_we) begin
         case (mem_read_size)
            2'd1: begin
               be_c    = alu_out[1] ? 4'b1100 : 4'b0011;
               wdata_c = {rt_val[15:0], rt_val[15:0]};
            end
            2'd2: begin
               be_c    = 4'b0001 << alu_out[1:0];
               wdata_c = {4{rt_val[7:0]}};
            end
            default: ;
         endcase
      end
      half_c = alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (alu_out[1:0])
         2'd0:    byte_c = dmem_rdata[7:0];
         2'd1:    byte_c = dmem_rdata[15:8];
         2'd2:    byte_c = dmem_rdata[23:16];
         default: byte_c = dmem_rdata[31:24];
      endcase
      case (mem_read_size)
         2'd1:    load_val = {{16{mem_sign_extend & half_c[15]}}, half_c};
         2'd2:    load_val = {{24{mem_sign_extend & byte_c[7]}}, byte_c};
         default: load_val = dmem_rdata;
      endcase
      case (r_dst)
         2'd0:    dst_c = insn[20:16];
         2'd1:    dst_c = insn[15:11];
         2'd2:    dst_c = 5'd31;
         default: dst_c = 5'd0;
      endcase
      case (rw_d)
         2'd0:    data_c = alu_out;
         2'd1:    data_c = load_val;
         2'd2:    data_c = pc + 32'd8;
         default: data_c = 32'd0;
      endcase
   end

   // Next state and the completion condition for this cycle.
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      if (state_q == ST_IDLE) begin
         complete = in_valid & ~start_op;
         if (start_op) state_d = ST_WAIT;
      end else if (dmem_ack) begin
         complete = 1'b1;
         state_d  = ST_IDLE;
      end
   end

   // Stall while an aligned access is outstanding; released in the ack cycle.
   assign stall = rst_n & start_op & ~((state_q == ST_WAIT) & dmem_ack);

   // FSM state and request fields captured when the access is launched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'd0;
         dmem_be_q    <= 4'd0;
         dmem_wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && start_op) begin
            dmem_we_q    <= dm_we;
            dmem_addr_q  <= {alu_out[31:2], 2'b00};
            dmem_be_q    <= dm_we ? be_c : 4'b1111;
            dmem_wdata_q <= dm_we ? wdata_c : 32'd0;
         end
      end
   end

   // Writeback register: valid only on edges where an instruction completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q     <= 1'b0;
         wb_r_we_q      <= 1'b0;
         misalign_err_q <= 1'b0;
         wb_dst_q       <= 5'd0;
         wb_data_q      <= 32'd0;
         wb_pc_q        <= 32'd0;
         wb_insn_q      <= 32'd0;
      end else begin
         wb_valid_q     <= complete;
         wb_r_we_q      <= complete & r_we & ~misaligned;
         misalign_err_q <= complete & misaligned;
         if (complete) begin
            wb_dst_q  <= dst_c;
            wb_data_q <= data_c;
            wb_pc_q   <= pc;
            wb_insn_q <= insn;
         end
      end
   end

   assign dmem_req     = (state_q == ST_WAIT);
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_be      = dmem_be_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_r_we      = wb_r_we_q;
   assign wb_dst       = wb_dst_q;
   assign wb_data      = wb_data_q;
   assign wb_pc        = wb_pc_q;
   assign wb_insn      = wb_insn_q;
   assign misalign_err = misalign_err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  execute-stage outputs hold a valid instruction.
- dm_we, r_we  in  1 each  store enable; register write enable.
- r_dst  in  2  0=rt (insn[20:16]), 1=rd (insn[15:11]), 2=r31.
- rw_d  in  2  writeback source: 0=ALU, 1=memory, 2=link (pc+8).
- mem_read_size  in  2  access size: 0=word, 1=half, 2=byte.
- mem_sign_extend  in  1  1=sign-extend loaded half/byte.
- pc, insn, alu_out, rt_val  in  32 each  from execute pipeline register.
- stall  out  1  holds execute-stage registers while high.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  request is a store.
- dmem_addr  out  32  {alu_out[31:2],2'b00}.
- dmem_be  out  4  byte enables, bit i = byte lane i.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  request complete; dmem_rdata valid this cycle.
- dmem_rdata  in  32  load data word.
- wb_valid, wb_r_we  out  1 each  writeback register valid; write enable.
- wb_dst  out  5  resolved destination register.
- wb_data  out  32  writeback value.
- wb_pc, wb_insn  out  32 each  passed through for trace.
- misalign_err  out  1  one-cycle pulse with wb_valid for a misaligned access.

Function
REQ-002 A memory op is in_valid & (dm_we | rw_d==1). Misaligned means half with alu_out[0]=1, or word with alu_out[1:0]!=0.
REQ-003 The FSM SHALL have states IDLE and WAIT. IDLE goes to WAIT on an aligned memory op. WAIT goes to IDLE on the edge where dmem_ack=1.
REQ-004 dmem_req SHALL equal (state==WAIT). dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL stay stable while dmem_req=1.
REQ-005 stall SHALL be combinational: in_valid & memop & aligned & !(state==WAIT & dmem_ack).
REQ-006 A non-memory or misaligned instruction SHALL load the wb_* registers on the next edge (latency 1, no stall).
REQ-007 A memory op SHALL load the wb_* registers on the ack edge. Minimum latency is 2 cycles (ack in the first WAIT cycle).
REQ-008 wb_valid SHALL be 0 on any edge where no instruction completes, including WAIT cycles with dmem_ack=0.
REQ-009 wb_dst SHALL be selected from insn by r_dst; r_dst=3 gives 0.
REQ-010 wb_data SHALL be alu_out (rw_d=0), the extracted load value (rw_d=1), or pc+8 (rw_d=2); rw_d=3 gives 0.
REQ-011 Byte lanes are little-endian. Store enables and data SHALL be:
- word: be=1111, wdata=rt_val.
- half: be=0011 if addr[1]=0 else 1100, wdata={rt[15:0],rt[15:0]}.
- byte: be=0001<<addr[1:0], wdata=rt[7:0] replicated 4 times.
- loads: be=1111, dmem_we=0.
REQ-012 The load value SHALL be the selected lane(s), sign- or zero-extended per mem_sign_extend. A word load is never extended.
REQ-013 A misaligned access SHALL issue no request and force wb_r_we=0, with wb_valid=1 and misalign_err=1 for that cycle.
REQ-014 dmem_ack in IDLE SHALL be ignored.
REQ-015 in_valid=0 SHALL produce wb_valid=0, wb_r_we=0, and no request.
REQ-016 wb_r_we SHALL equal r_we & wb_valid, except as forced by REQ-013.

Reset
REQ-017 While rst_n=0:
- state=IDLE, dmem_req=0, stall=0.
- all wb_* outputs, misalign_err, dmem_we, dmem_be, dmem_addr and dmem_wdata are 0.
REQ-018 Reset during WAIT SHALL drop dmem_req asynchronously and abandon the access. A later dmem_ack SHALL be ignored.
REQ-019 The first edge after rst_n rises SHALL start from IDLE.

Verification
REQ-020 addu: rw_d=0, r_dst=1, insn[15:11]=5, alu_out=0x1234 -> next cycle wb_valid=1, wb_dst=5, wb_data=0x1234, stall never high.
REQ-021 sb at alu_out=0x103, rt=0xAB:
- -> one stall cycle, then dmem_req=1, be=1000, wdata=0xABABABAB, addr=0x100.
- ack after 3 WAIT cycles -> stall drops that cycle, wb_valid on the ack edge.
REQ-022 lh at 0x202 with rdata=0x8001xxxx:
- sign_extend=1 -> wb_data=0xFFFF8001.
- lhu (sign_extend=0) -> wb_data=0x00008001.
REQ-023 lw at 0x301 -> no dmem_req, misalign_err=1 one cycle, wb_r_we=0.
REQ-024 jal: rw_d=2, r_dst=2, pc=0x400 -> wb_dst=31, wb_data=0x408.
REQ-025 rst_n low during WAIT -> dmem_req=0 immediately. A subsequent ack -> no wb_valid; the next instruction processes normally.
